// File: rtl/ao486_ifill_sequencer_if.sv
// rtl/ao486_ifill_sequencer_if.sv - IMISS request / L1.5 response bundle between the fetch sequencer and the transducer
interface ao486_ifill_sequencer_if;
  logic        ifill_req_val;
  logic [39:0] ifill_req_addr;
  logic [4:0]  ifill_req_rqtype;
  logic [2:0]  ifill_req_size;
  logic        ifill_req_ack;
  logic        l15_resp_val;
  logic [3:0]  l15_resp_returntype;
  logic [63:0] l15_resp_data_2;
  logic [63:0] l15_resp_data_3;
  logic        l15_resp_ack;

  modport master (
    output ifill_req_val, ifill_req_addr, ifill_req_rqtype, ifill_req_size, l15_resp_ack,
    input  ifill_req_ack, l15_resp_val, l15_resp_returntype, l15_resp_data_2, l15_resp_data_3
  );

  modport slave (
    input  ifill_req_val, ifill_req_addr, ifill_req_rqtype, ifill_req_size, l15_resp_ack,
    output ifill_req_ack, l15_resp_val, l15_resp_returntype, l15_resp_data_2, l15_resp_data_3
  );
endinterface

// File: rtl/ao486_ifill_sequencer.sv
// rtl/ao486_ifill_sequencer.sv - ao486 readcode to L1.5 IMISS/IFILL sequencer, one outstanding fetch
// Optional response watchdog enabled by defining AO486_IFILL_TIMEOUT_EN.
`ifndef IMISS_RQ
`define IMISS_RQ 5'b10000
`endif
`ifndef PCX_SZ_4B
`define PCX_SZ_4B 3'b010
`endif
`ifndef IFILL_RET
`define IFILL_RET 4'b0001
`endif

module ao486_ifill_sequencer #(
  parameter int ADDR_WIDTH       = 32,
  parameter int LINE_OFFSET_BITS = 5,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_released,
  input  logic                  request_readcode_do,
  input  logic [ADDR_WIDTH-1:0] request_readcode_address,
  ao486_ifill_sequencer_if.master l15,
  output logic [31:0]           readcode_partial,
  output logic [127:0]          readcode_line,
  output logic                  readcode_partial_done,
  output logic                  readcode_done,
  output logic                  ifill_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-LINE_OFFSET_BITS-1:0] req_line_q;
  logic                                   served_q;
  logic [1:0]                             beat_q;
  logic [127:0]                           line_q;

  logic                  capture;
  logic                  resp_hit;
  logic                  timeout_hit;
  logic [ADDR_WIDTH-1:0] line_addr;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign line_addr = {req_line_q, {LINE_OFFSET_BITS{1'b0}}};
  assign capture   = (state_q == S_IDLE) && request_readcode_do && core_released && !served_q;
  assign resp_hit  = (state_q == S_WAIT) && l15.l15_resp_val &&
                     (l15.l15_resp_returntype == `IFILL_RET);

`ifdef AO486_IFILL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wait_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_WAIT && state_d == S_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign timeout_hit = (state_q == S_WAIT) && !resp_hit &&
                       (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign ifill_timeout = timeout_hit;

  always_comb begin
    state_d                 = state_q;
    l15.ifill_req_val       = 1'b0;
    l15.ifill_req_addr      = '0;
    l15.ifill_req_rqtype    = '0;
    l15.ifill_req_size      = '0;
    l15.l15_resp_ack        = 1'b0;
    readcode_partial        = '0;
    readcode_line           = '0;
    readcode_partial_done   = 1'b0;
    readcode_done           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (capture) state_d = S_REQ;
      end
      S_REQ: begin
        l15.ifill_req_val    = 1'b1;
        l15.ifill_req_addr   = {{(40-ADDR_WIDTH){line_addr[ADDR_WIDTH-1]}}, line_addr};
        l15.ifill_req_rqtype = `IMISS_RQ;
        l15.ifill_req_size   = `PCX_SZ_4B;
        if (l15.ifill_req_ack) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_hit) begin
          l15.l15_resp_ack = 1'b1;
          state_d          = S_DRAIN;
        end else if (timeout_hit) begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        // P0 sits in the top dword; beat k exposes P0..Pk, lower dwords stay zero
        readcode_partial      = line_q[{~beat_q, 5'b0} +: 32];
        readcode_line         = line_q & {{32{1'b1}}, {32{beat_q != 2'd0}},
                                          {32{beat_q[1]}}, {32{beat_q == 2'd3}}};
        readcode_partial_done = (beat_q != 2'd3);
        readcode_done         = (beat_q == 2'd3);
        if (beat_q == 2'd3) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_line_q <= '0;
      served_q   <= 1'b0;
      beat_q     <= 2'd0;
      line_q     <= '0;
    end else begin
      state_q <= state_d;
      if (capture) req_line_q <= request_readcode_address[ADDR_WIDTH-1:LINE_OFFSET_BITS];
      if (resp_hit) begin
        line_q <= {bswap32(l15.l15_resp_data_2[63:32]), bswap32(l15.l15_resp_data_2[31:0]),
                   bswap32(l15.l15_resp_data_3[63:32]), bswap32(l15.l15_resp_data_3[31:0])};
      end
      beat_q <= (state_q == S_DRAIN) ? beat_q + 2'd1 : 2'd0;
      // served blocks re-issue while the core keeps do high after completion
      if (state_q == S_DRAIN && beat_q == 2'd3) begin
        served_q <= 1'b1;
      end else if (!request_readcode_do) begin
        served_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ao486_ifill_sequencer.sv
// tb/tb_ao486_ifill_sequencer.sv - directed self-checking bench for ao486_ifill_sequencer
module tb_ao486_ifill_sequencer;

  localparam logic [4:0] IMISS_RQ  = 5'b10000;
  localparam logic [2:0] PCX_SZ_4B = 3'b010;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] LOAD_RET  = 4'b0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         core_released;
  logic         request_readcode_do;
  logic [31:0]  request_readcode_address;
  logic [31:0]  readcode_partial;
  logic [127:0] readcode_line;
  logic         readcode_partial_done;
  logic         readcode_done;
  logic         ifill_timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  ao486_ifill_sequencer_if bus ();

  ao486_ifill_sequencer dut (
    .clk                      (clk),
    .rst                      (rst),
    .core_released            (core_released),
    .request_readcode_do      (request_readcode_do),
    .request_readcode_address (request_readcode_address),
    .l15                      (bus),
    .readcode_partial         (readcode_partial),
    .readcode_line            (readcode_line),
    .readcode_partial_done    (readcode_partial_done),
    .readcode_done            (readcode_done),
    .ifill_timeout            (ifill_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic finish_fetch(input logic [63:0] d2, input logic [63:0] d3);
    bus.l15_resp_val        = 1'b1;
    bus.l15_resp_returntype = IFILL_RET;
    bus.l15_resp_data_2     = d2;
    bus.l15_resp_data_3     = d3;
    tick;
    bus.l15_resp_val = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick;
    tests_run++;
    if ({bus.ifill_req_val, bus.ifill_req_addr, bus.ifill_req_rqtype, bus.ifill_req_size,
         bus.l15_resp_ack, readcode_partial, readcode_line, readcode_partial_done,
         readcode_done, ifill_timeout} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: val=%b addr=%h line=%h done=%b, required all zero",
               bus.ifill_req_val, bus.ifill_req_addr, readcode_line, readcode_done);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [31:0]  exp_p [4];
    logic [127:0] exp_full;
    logic [127:0] exp_line;
    exp_p    = '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
    exp_full = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
    core_released            = 1'b1;
    request_readcode_do      = 1'b1;
    request_readcode_address = 32'h0000_1234;
    tick;
    tests_run++;
    if ({bus.ifill_req_val, bus.ifill_req_addr, bus.ifill_req_rqtype, bus.ifill_req_size} !==
        {1'b1, 40'h00_0000_1220, IMISS_RQ, PCX_SZ_4B}) begin
      tests_failed++;
      $display("FAIL basic_req: val=%b addr=%h rqtype=%h size=%h, required 1 0000001220 %h %h",
               bus.ifill_req_val, bus.ifill_req_addr, bus.ifill_req_rqtype, bus.ifill_req_size,
               IMISS_RQ, PCX_SZ_4B);
    end
    bus.ifill_req_ack = 1'b1;
    tick;
    bus.ifill_req_ack = 1'b0;
    tests_run++;
    if ({bus.ifill_req_val, bus.ifill_req_rqtype} !== 6'd0) begin
      tests_failed++;
      $display("FAIL basic_val_drop: val=%b rqtype=%h, required 0 0", bus.ifill_req_val,
               bus.ifill_req_rqtype);
    end
    bus.l15_resp_val        = 1'b1;
    bus.l15_resp_returntype = IFILL_RET;
    bus.l15_resp_data_2     = 64'h0011223344556677;
    bus.l15_resp_data_3     = 64'h8899AABBCCDDEEFF;
    #1;
    tests_run++;
    if (bus.l15_resp_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_resp_ack: got %b, required 1", bus.l15_resp_ack);
    end
    tick;
    bus.l15_resp_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_line = (exp_full >> (96 - 32*k)) << (96 - 32*k);
      tests_run++;
      if ({readcode_partial, readcode_line, readcode_partial_done, readcode_done} !==
          {exp_p[k], exp_line, (k != 3), (k == 3)}) begin
        tests_failed++;
        $display("FAIL basic_beat%0d: partial=%h line=%h pd=%b done=%b, required %h %h %b %b",
                 k, readcode_partial, readcode_line, readcode_partial_done, readcode_done,
                 exp_p[k], exp_line, (k != 3), (k == 3));
      end
      tick;
    end
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({bus.ifill_req_val, readcode_partial, readcode_line, readcode_done} !== '0) begin
        tests_failed++;
        $display("FAIL basic_hold%0d: val=%b partial=%h done=%b, required all zero", i,
                 bus.ifill_req_val, readcode_partial, readcode_done);
      end
      tick;
    end
    request_readcode_do = 1'b0;
    tick;
  endtask

  task automatic test_delayed_ack;
    int issued;
    issued = 0;
    request_readcode_do      = 1'b1;
    request_readcode_address = 32'h0000_2010;
    tick;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({bus.ifill_req_val, bus.ifill_req_addr, bus.ifill_req_rqtype} !==
          {1'b1, 40'h00_0000_2000, IMISS_RQ}) begin
        tests_failed++;
        $display("FAIL delayed_ack_hold%0d: val=%b addr=%h rqtype=%h, required 1 0000002000 %h",
                 i, bus.ifill_req_val, bus.ifill_req_addr, bus.ifill_req_rqtype, IMISS_RQ);
      end
      if (bus.ifill_req_val && bus.ifill_req_ack) issued++;
      tick;
    end
    bus.ifill_req_ack = 1'b1;
    if (bus.ifill_req_val && bus.ifill_req_ack) issued++;
    tick;
    bus.ifill_req_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus.ifill_req_val && bus.ifill_req_ack) issued++;
      tick;
    end
    bus.ifill_req_ack = 1'b0;
    tests_run++;
    if (issued !== 1) begin
      tests_failed++;
      $display("FAIL delayed_ack_issue_count: got %0d, required 1", issued);
    end
    finish_fetch(64'h0, 64'h0);
    request_readcode_do = 1'b0;
    tick;
  endtask

  task automatic test_high_addr;
    request_readcode_do      = 1'b1;
    request_readcode_address = 32'h8000_0040;
    tick;
    tests_run++;
    if (bus.ifill_req_addr !== 40'hFF_8000_0040) begin
      tests_failed++;
      $display("FAIL high_addr: got %h, required ff80000040", bus.ifill_req_addr);
    end
    bus.ifill_req_ack = 1'b1;
    tick;
    bus.ifill_req_ack = 1'b0;
    finish_fetch(64'h0, 64'h0);
    request_readcode_do = 1'b0;
    tick;
  endtask

  task automatic test_wrong_type;
    logic [31:0] exp_p [4];
    exp_p = '{32'h04030201, 32'h08070605, 32'h14131211, 32'h18171615};
    request_readcode_do      = 1'b1;
    request_readcode_address = 32'h0000_4000;
    tick;
    bus.ifill_req_ack = 1'b1;
    tick;
    bus.ifill_req_ack       = 1'b0;
    bus.l15_resp_val        = 1'b1;
    bus.l15_resp_returntype = LOAD_RET;
    bus.l15_resp_data_2     = 64'h0102030405060708;
    bus.l15_resp_data_3     = 64'h1112131415161718;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({bus.l15_resp_ack, readcode_partial_done, readcode_done, ifill_timeout} !== 4'b0) begin
        tests_failed++;
        $display("FAIL wrong_type_ignored%0d: ack=%b pd=%b done=%b to=%b, required 0 0 0 0", i,
                 bus.l15_resp_ack, readcode_partial_done, readcode_done, ifill_timeout);
      end
      tick;
    end
    bus.l15_resp_returntype = IFILL_RET;
    #1;
    tests_run++;
    if (bus.l15_resp_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrong_type_then_ifill_ack: got %b, required 1", bus.l15_resp_ack);
    end
    tick;
    bus.l15_resp_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({readcode_partial, readcode_partial_done, readcode_done} !==
          {exp_p[k], (k != 3), (k == 3)}) begin
        tests_failed++;
        $display("FAIL wrong_type_beat%0d: partial=%h pd=%b done=%b, required %h %b %b", k,
                 readcode_partial, readcode_partial_done, readcode_done, exp_p[k], (k != 3),
                 (k == 3));
      end
      tick;
    end
    request_readcode_do = 1'b0;
    tick;
  endtask

  task automatic test_gating;
    core_released            = 1'b0;
    request_readcode_do      = 1'b1;
    request_readcode_address = 32'h0000_5000;
    bus.l15_resp_val         = 1'b1;
    bus.l15_resp_returntype  = IFILL_RET;
    for (int i = 0; i < 4; i++) begin
      tick;
      tests_run++;
      if ({bus.ifill_req_val, bus.l15_resp_ack} !== 2'b00) begin
        tests_failed++;
        $display("FAIL gating_blocked%0d: val=%b resp_ack=%b, required 0 0", i,
                 bus.ifill_req_val, bus.l15_resp_ack);
      end
    end
    bus.l15_resp_val = 1'b0;
    core_released    = 1'b1;
    tick;
    tests_run++;
    if (bus.ifill_req_val !== 1'b1) begin
      tests_failed++;
      $display("FAIL gating_release: val=%b, required 1", bus.ifill_req_val);
    end
    bus.ifill_req_ack = 1'b1;
    tick;
    bus.ifill_req_ack = 1'b0;
    core_released     = 1'b0;
    finish_fetch(64'h0, 64'h0);
    core_released = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus.ifill_req_val !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_no_reissue%0d: val=%b, required 0", i, bus.ifill_req_val);
      end
      tick;
    end
    request_readcode_do = 1'b0;
    tick;
    request_readcode_do = 1'b1;
    tick;
    tests_run++;
    if (bus.ifill_req_val !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_reissue_after_toggle: val=%b, required 1", bus.ifill_req_val);
    end
    bus.ifill_req_ack = 1'b1;
    tick;
    bus.ifill_req_ack = 1'b0;
    finish_fetch(64'h0, 64'h0);
    request_readcode_do = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_drain;
    int done_seen;
    done_seen = 0;
    request_readcode_do      = 1'b1;
    request_readcode_address = 32'h0000_6000;
    tick;
    bus.ifill_req_ack = 1'b1;
    tick;
    bus.ifill_req_ack       = 1'b0;
    bus.l15_resp_val        = 1'b1;
    bus.l15_resp_returntype = IFILL_RET;
    bus.l15_resp_data_2     = 64'h0011223344556677;
    bus.l15_resp_data_3     = 64'h8899AABBCCDDEEFF;
    tick;
    bus.l15_resp_val = 1'b0;
    tick;
    tests_run++;
    if ({readcode_partial, readcode_partial_done} !== {32'h77665544, 1'b1}) begin
      tests_failed++;
      $display("FAIL rst_drain_beat2: partial=%h pd=%b, required 77665544 1", readcode_partial,
               readcode_partial_done);
    end
    rst                 = 1'b1;
    request_readcode_do = 1'b0;
    tick;
    tests_run++;
    if ({bus.ifill_req_val, bus.ifill_req_addr, bus.l15_resp_ack, readcode_partial,
         readcode_line, readcode_partial_done, readcode_done} !== '0) begin
      tests_failed++;
      $display("FAIL rst_drain_outputs: val=%b partial=%h line=%h pd=%b done=%b, required 0",
               bus.ifill_req_val, readcode_partial, readcode_line, readcode_partial_done,
               readcode_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (readcode_done || readcode_partial_done) done_seen++;
      tick;
    end
    tests_run++;
    if (done_seen !== 0) begin
      tests_failed++;
      $display("FAIL rst_drain_no_done: saw %0d beats, required 0", done_seen);
    end
    bus.l15_resp_val = 1'b1;
    #1;
    tests_run++;
    if (bus.l15_resp_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_late_resp_ack: got %b, required 0", bus.l15_resp_ack);
    end
    tick;
    bus.l15_resp_val = 1'b0;
    tests_run++;
    if ({readcode_partial_done, readcode_line} !== '0) begin
      tests_failed++;
      $display("FAIL rst_late_resp_drain: pd=%b line=%h, required 0", readcode_partial_done,
               readcode_line);
    end
    tick;
  endtask

  initial begin
    rst                      = 1'b1;
    core_released            = 1'b0;
    request_readcode_do      = 1'b0;
    request_readcode_address = '0;
    bus.ifill_req_ack        = 1'b0;
    bus.l15_resp_val         = 1'b0;
    bus.l15_resp_returntype  = '0;
    bus.l15_resp_data_2      = '0;
    bus.l15_resp_data_3      = '0;
    test_reset;
    test_basic;
    test_delayed_ack;
    test_high_addr;
    test_wrong_type;
    test_gating;
    test_reset_mid_drain;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/ao486_ifill_sequencer.md
Name: ao486_ifill_sequencer

Overview:
- Sits between the ao486 core's instruction-fetch port and the L1.5 transducer datapath.
- Turns a core readcode request into a single line-aligned IMISS request with a val/ack handshake.
- Captures the matching IFILL return, byte-swaps the big-endian payload to little-endian, and replays it to the core as four 32-bit partials on four consecutive cycles.
- Tracks exactly one outstanding fetch. A core release gate blocks all traffic until the core is out of reset.

Parameters:
- ADDR_WIDTH, 32, core address width; the request address is sign-extended to 40 bits.
- LINE_OFFSET_BITS, 5, low address bits zeroed for the line-aligned request (32-byte L1.5 line).
- TIMEOUT_CYCLES, 1024, response watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- core_released  in  1  high once the ao486 has been released from reset; low blocks new requests
- request_readcode_do  in  1  core fetch request, level, held until done
- request_readcode_address  in  32  core fetch address
- ifill_req_val  out  1  request valid to the L1.5 issue stage
- ifill_req_addr  out  40  line-aligned, sign-extended request address
- ifill_req_rqtype  out  5  `IMISS_RQ while val is high, else 0
- ifill_req_size  out  3  `PCX_SZ_4B while val is high, else 0
- ifill_req_ack  in  1  header accepted by L1.5
- l15_resp_val  in  1  L1.5 response valid
- l15_resp_returntype  in  4  response type
- l15_resp_data_2  in  64  response doubleword 2
- l15_resp_data_3  in  64  response doubleword 3
- l15_resp_ack  out  1  response consumed
- readcode_partial  out  32  current dword to core
- readcode_line  out  128  accumulated line to core
- readcode_partial_done  out  1  pulse per partial
- readcode_done  out  1  pulse on final partial
- ifill_timeout  out  1  watchdog pulse (optional feature only; otherwise tied 0)

Behaviour:
- Reset values: every output 0; FSM in IDLE; beat counter 0; line buffer 0.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE → REQ: requires request_readcode_do & core_released & ~served.
  - Captures addr[31:LINE_OFFSET_BITS] into the request register.
  - ifill_req_val rises the next cycle.
- REQ: ifill_req_val, rqtype and size are held stable until ifill_req_ack is sampled high, then → WAIT.
  - If ack arrives in the first REQ cycle, the request is still counted as issued exactly once.
- WAIT: on l15_resp_val & returntype==`IFILL_RET:
  - l15_resp_ack pulses for one cycle.
  - Partials P0..P3 are loaded. P0 = bswap32(data_2[63:32]), P1 = bswap32(data_2[31:0]), P2 = bswap32(data_3[63:32]), P3 = bswap32(data_3[31:0]).
  - State → DRAIN.
- WAIT, other returntypes: not consumed (l15_resp_ack stays 0); state unchanged.
- DRAIN, beats k = 0..3 on consecutive cycles:
  - readcode_partial = Pk.
  - readcode_line holds P0..Pk packed from MSB, zero-filled below.
  - readcode_partial_done = 1 for k = 0..2.
  - On k = 3, readcode_done = 1 and readcode_partial_done = 0.
  - After k = 3 → IDLE with served = 1.
- First partial appears 1 cycle after the response cycle. Total latency from do to readcode_done is at least 6 cycles when ack and response are immediate.
- served clears when request_readcode_do is sampled low. If do is still high the cycle after done, no re-issue occurs.
- Outside DRAIN: readcode_partial, readcode_line and the pulse outputs are 0.
- Response in IDLE/REQ/DRAIN: ignored, not acked.
- rst mid-operation: returns to IDLE in the same edge, drops val and discards the buffer. A late response is then ignored.
- core_released falling mid-operation: the in-flight fetch completes; no new request is captured.

Optional Feature:
- Macro AO486_IFILL_TIMEOUT_EN.
- When defined: a counter runs in WAIT.
  - On reaching TIMEOUT_CYCLES−1 without a response, ifill_timeout pulses for one cycle, the counter clears and the FSM → REQ to reissue the same address.
  - The counter clears on every WAIT exit.
- When undefined: no counter logic; ifill_timeout is tied 0; WAIT persists indefinitely.

Test Plan:
- Basic fetch:
  - Stimulus: do = 1 with addr 0x0000_1234; ack on the first val cycle; response with data_2 = 0x0011223344556677, data_3 = 0x8899AABBCCDDEEFF.
  - Required: ifill_req_addr = 0x00_0000_1220, rqtype = `IMISS_RQ; partials 0x33221100, 0x77665544, 0xBBAA9988, 0xFFEEDDCC; final readcode_line = {P0,P1,P2,P3}; done only on beat 4.
- Delayed ack: ack held low 5 cycles → val, addr and rqtype stable for all 5 cycles; exactly one request issued.
- High address: addr 0x8000_0040 → ifill_req_addr = 0xFF_8000_0040.
- Wrong response type: a LOAD_RET response in WAIT → not acked, no partials; the following IFILL_RET completes normally.
- Gating and hold: do = 1 while core_released = 0 → no val. do held high after done → no second request until do toggles low then high.
- Reset mid-DRAIN: rst asserted on beat 2 → all outputs 0 the next cycle; no readcode_done. With AO486_IFILL_TIMEOUT_EN and TIMEOUT_CYCLES = 16 and no response → ifill_timeout pulse after 16 WAIT cycles, then val re-asserts with the same address.
